cover_toggle_sched: RTL and testbench
=====================================

# cover_toggle_sched

Toggle-coverage event scheduler for the formal/fuzz coverage flow. It sits between the instrumented design's per-group toggle hit vectors and a single downstream coverage reporting port. It records first hits only, queues them, and serializes them one index per handshake. Groups are served by round-robin arbitration so no group starves the reporter.

## Interface
- WIDTH, 9, hit bits per group
- GROUPS, 4, number of requesting groups
- COVER_INDEX, 0, global index of group 0 bit 0
- IDX_W, 64, width of emitted index
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserts immediately, deasserts synchronously to clock
- enable  in  1  hits sampled only when 1
- hit  in  GROUPS*WIDTH  group g bit b at hit[g*WIDTH+b]; level, sampled every cycle
- clear  in  1  one-cycle pulse; re-arms all coverage points
- out_valid  out  1  out_index holds a reportable index
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_index  out  IDX_W  COVER_INDEX + g*WIDTH + b
- reported  out  clog2(GROUPS*WIDTH+1)  count of accepted indices since reset/clear
- all_done  out  1  every point has been accepted at least once

## Operation
- Per-point state: IDLE (never hit), PEND (hit, queued), FLIGHT (in output register), SEEN (accepted). A bitmap per state is sufficient.
- IDLE→PEND: the hit bit is 1 and enable=1 at an edge. A hit on a PEND/FLIGHT/SEEN point is ignored, which deduplicates repeated toggles.
- PEND→FLIGHT: the output register is empty, or it is emptying this cycle (accept). The scheduler then selects one PEND point:
  - Group: round-robin starting at rr_ptr, first group with any PEND bit.
  - Bit: lowest-numbered PEND bit in that group.
  - rr_ptr then becomes (granted group + 1) mod GROUPS.
- FLIGHT→SEEN on accept; reported increments by 1.
- Back-to-back: accept and reload in the same cycle give one index per cycle under a continuous out_ready.
- clear: every PEND and SEEN point returns to IDLE, reported is set to 0, rr_ptr is set to 0.
  - An in-flight entry is not dropped. It stays valid until accepted and then counts as 1 in the new epoch.
  - Hits in the clear cycle are discarded.
- all_done = (reported == GROUPS*WIDTH).

## Timing
- Reset values:
  - out_valid=0, out_index=0, reported=0, all_done=0.
  - All points IDLE, rr_ptr=0.
- Latency: hit sampled at edge t makes the point PEND. At edge t+1 it is loaded, so out_valid=1 from t+1. Minimum hit-to-valid latency is 2 edges.
- Handshake: while out_valid=1 and out_ready=0, out_valid and out_index hold stable. out_valid never drops without accept.
- Simultaneous hit of the point being accepted: the point becomes SEEN and the hit is ignored.
- Simultaneous clear and accept: the accept is counted in the new epoch (reported=1 after the edge).
- Reset mid-operation: all state returns to reset values asynchronously. A partial handshake is lost.
- Width: out_index = COVER_INDEX + g*WIDTH + b, computed in IDX_W bits. No wrap check is performed; COVER_INDEX + GROUPS*WIDTH must fit in IDX_W.

## Structure
- Shared package cover_pkg:
  - IDX_W default.
  - Point-state encoding (IDLE/PEND/FLIGHT/SEEN).
  - Function to compute the flat bit position g*WIDTH+b.
- Sub-module cover_rr_pick: combinational round-robin group select plus lowest-bit encoder.
  - Inputs: PEND bitmap, rr_ptr.
  - Outputs: grant_valid, grant_group, grant_bit.
- Top level holds the bitmaps, output register, rr_ptr, counter, and clear/enable gating.

## Test plan
- Single hit g1b3 (COVER_INDEX=100), out_ready=1 → out_valid at the 2nd edge with out_index=112; reported=1; repeated hits on g1b3 produce nothing.
- All 36 bits hit in one cycle, out_ready=1 → 36 consecutive indices in order 100,109,118,127,101,110,… ending at 135; then all_done=1 and out_valid=0.
- Same as previous with out_ready toggling 1/0 → each index is held stable while not ready; no loss or duplicate; reported=36.
- Accept index 100, then pulse clear while 109 is in flight with out_ready=0 → 109 remains valid; after accept reported=1; a fresh hit on g0b0 emits 100 again.
- Hits with enable=0 → no PEND, out_valid stays 0.
- Reset low while out_valid=1 with 5 points pending → outputs 0 immediately; after release the same hits are re-reported from scratch.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-coverage scheduler.
// Holds the index width default, point-state names and flat position math.
package cover_pkg;

    localparam int IDX_W_DEF = 64;

    typedef enum logic [1:0] {
        PT_IDLE,
        PT_PEND,
        PT_FLIGHT,
        PT_SEEN
    } point_state_t;

    function automatic int unsigned flat_pos(
        input int unsigned g,
        input int unsigned b,
        input int unsigned w
    );
        return g * w + b;
    endfunction

endpackage

// File: rtl/cover_toggle_sched_if.sv
// Valid/ready coverage report channel carrying one global cover index.
// Ports: out_valid, out_index (master drives), out_ready (slave drives).
interface cover_toggle_sched_if #(
    parameter int IDX_W = 64
) ();

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        output out_ready
    );

endinterface

// File: rtl/cover_rr_pick.sv
// Combinational round-robin group select plus lowest pending bit encoder.
// Ports: pend bitmap, rr_ptr in; grant_valid, grant_group, grant_bit out.
module cover_rr_pick
    import cover_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int GROUPS = 4,
    parameter int GW     = 2,
    parameter int BW     = 4
) (
    input  logic [GROUPS*WIDTH-1:0] pend,
    input  logic [GW-1:0]           rr_ptr,
    output logic                    grant_valid,
    output logic [GW-1:0]           grant_group,
    output logic [BW-1:0]           grant_bit
);

    logic [WIDTH-1:0] row;

    function automatic int unsigned wrap(
        input int unsigned p,
        input int unsigned i
    );
        return (p + i) % GROUPS;
    endfunction

    // First group at or after rr_ptr (circularly) with any pending bit.
    always_comb begin
        grant_valid = 1'b0;
        grant_group = '0;
        for (int i = 0; i < GROUPS; i++) begin
            if (!grant_valid &&
                (|pend[wrap(32'(rr_ptr), i)*WIDTH +: WIDTH])) begin
                grant_valid = 1'b1;
                grant_group = GW'(wrap(32'(rr_ptr), i));
            end
        end
    end

    assign row = pend[32'(grant_group)*WIDTH +: WIDTH];

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        grant_bit = '0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (row[b]) begin
                grant_bit = BW'(b);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// Records first toggle hits per point, queues them and reports one
// global index per handshake. Ports: clock, reset (async low), enable,
// hit, clear, report (valid/ready channel), reported count, all_done.
module cover_toggle_sched
    import cover_pkg::*;
#(
    parameter int               WIDTH       = 9,
    parameter int               GROUPS      = 4,
    parameter int               IDX_W       = IDX_W_DEF,
    parameter logic [IDX_W-1:0] COVER_INDEX = '0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [GROUPS*WIDTH-1:0]             hit,
    input  logic                                clear,
    cover_toggle_sched_if.master                report,
    output logic [$clog2(GROUPS*WIDTH+1)-1:0]   reported,
    output logic                                all_done
);

    localparam int NPTS = GROUPS * WIDTH;
    localparam int CW   = $clog2(NPTS + 1);
    localparam int GW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // One bitmap per non-idle point state; idle is the absence of all three.
    logic [NPTS-1:0]  pend;
    logic [NPTS-1:0]  flight;
    logic [NPTS-1:0]  seen;
    logic [GW-1:0]    rr_ptr;
    logic             valid_q;
    logic [IDX_W-1:0] index_q;
    logic [CW-1:0]    count_q;

    logic             grant_valid;
    logic [GW-1:0]    grant_group;
    logic [BW-1:0]    grant_bit;
    int unsigned      grant_pos;
    logic [NPTS-1:0]  grant_mask;
    logic [NPTS-1:0]  fresh;
    logic             accept;
    logic             load;
    logic [GW-1:0]    rr_next;

    cover_rr_pick #(
        .WIDTH  (WIDTH),
        .GROUPS (GROUPS),
        .GW     (GW),
        .BW     (BW)
    ) u_pick (
        .pend        (pend),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_group (grant_group),
        .grant_bit   (grant_bit)
    );

    assign accept = valid_q & report.out_ready;

    // Clear wipes the pending set, so nothing is loaded in that cycle.
    assign load = grant_valid & ~clear & (~valid_q | accept);

    assign grant_pos  = flat_pos(32'(grant_group), 32'(grant_bit), WIDTH);
    assign grant_mask = NPTS'(load) << grant_pos;

    // Only idle points take a hit; this is what deduplicates toggles.
    assign fresh = (enable & ~clear) ? (hit & ~(pend | flight | seen)) : '0;

    assign rr_next = (grant_group == GW'(GROUPS - 1)) ? '0
                                                      : grant_group + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            flight  <= '0;
            seen    <= '0;
            rr_ptr  <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            count_q <= '0;
        end else begin
            pend   <= (clear ? '0 : (pend & ~grant_mask)) | fresh;
            flight <= (accept ? '0 : flight) | grant_mask;
            // An accept in the clear cycle belongs to the new epoch.
            seen   <= (clear ? '0 : seen) | (accept ? flight : '0);

            if (clear) begin
                rr_ptr <= '0;
            end else if (load) begin
                rr_ptr <= rr_next;
            end

            if (load) begin
                valid_q <= 1'b1;
                index_q <= COVER_INDEX + IDX_W'(grant_pos);
            end else if (accept) begin
                valid_q <= 1'b0;
            end

            if (clear) begin
                count_q <= CW'(accept);
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign report.out_valid = valid_q;
    assign report.out_index = index_q;
    assign reported         = count_q;
    assign all_done         = (count_q == CW'(NPTS));

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Self-checking bench for cover_toggle_sched: directed scenarios plus a
// randomized run against a point-level behavioural model.
module tb_cover_toggle_sched;
    import cover_pkg::*;

    localparam int          W  = 9;
    localparam int          G  = 4;
    localparam int          N  = G * W;
    localparam logic [63:0] CI = 64'd100;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic         enable = 1'b0;
    logic         clear  = 1'b0;
    logic [N-1:0] hit    = '0;
    logic [5:0]   reported;
    logic         all_done;

    int n_checks = 0;
    int n_fail   = 0;

    cover_toggle_sched_if #(.IDX_W(64)) rep_if ();

    cover_toggle_sched #(
        .WIDTH       (W),
        .GROUPS      (G),
        .IDX_W       (64),
        .COVER_INDEX (CI)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .hit      (hit),
        .clear    (clear),
        .report   (rep_if),
        .reported (reported),
        .all_done (all_done)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    point_state_t m_st [N];
    bit           m_valid;
    logic [63:0]  m_idx;
    int           m_cnt;
    int           m_rr;
    int           m_fpos;

    function automatic void model_reset();
        foreach (m_st[p]) m_st[p] = PT_IDLE;
        m_valid = 0;
        m_idx   = '0;
        m_cnt   = 0;
        m_rr    = 0;
        m_fpos  = 0;
    endfunction

    // Apply one clock edge worth of spec rules to the model.
    function automatic void model_step(input logic [N-1:0] h, input bit en,
                                       input bit clr, input bit rdy);
        bit acc;
        bit newp [N];
        int pg;
        int pb;
        acc = m_valid && rdy;
        pg  = -1;
        pb  = -1;
        for (int p = 0; p < N; p++)
            newp[p] = en && !clr && h[p] && (m_st[p] == PT_IDLE);
        for (int i = 0; i < G && pg < 0; i++) begin
            for (int b = W - 1; b >= 0; b--) begin
                if (m_st[((m_rr + i) % G) * W + b] == PT_PEND) begin
                    pg = (m_rr + i) % G;
                    pb = b;
                end
            end
        end
        if (clr) begin
            for (int p = 0; p < N; p++)
                if (m_st[p] == PT_PEND || m_st[p] == PT_SEEN)
                    m_st[p] = PT_IDLE;
            m_cnt = 0;
            m_rr  = 0;
        end
        if (acc) begin
            m_st[m_fpos] = PT_SEEN;
            m_cnt++;
            m_valid = 0;
        end
        if (!clr && pg >= 0 && !m_valid) begin
            m_fpos       = pg * W + pb;
            m_st[m_fpos] = PT_FLIGHT;
            m_valid      = 1;
            m_idx        = CI + 64'(m_fpos);
            m_rr         = (pg + 1) % G;
        end
        for (int p = 0; p < N; p++)
            if (newp[p]) m_st[p] = PT_PEND;
    endfunction

    // Expected order when every point is pending at once from rr_ptr=0.
    function automatic logic [63:0] full_order(input int k);
        return CI + 64'((k % G) * W + k / G);
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        hit              = '0;
        enable           = 1'b0;
        clear            = 1'b0;
        rep_if.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0", rep_if.out_valid);
        end
        n_checks++;
        if (rep_if.out_index !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_index got=%0d exp=0", rep_if.out_index);
        end
        n_checks++;
        if (reported !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_reported got=%0d exp=0", reported);
        end
        n_checks++;
        if (all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_all_done got=%b exp=0", all_done);
        end
    endtask

    task automatic test_single();
        enable           = 1'b1;
        rep_if.out_ready = 1'b1;
        hit              = '0;
        hit[1*W+3]       = 1'b1;
        tick();
        hit = '0;
        n_checks++;
        if (rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge1 valid got=%b exp=0", rep_if.out_valid);
        end
        tick();
        n_checks++;
        if (rep_if.out_valid !== 1'b1 || rep_if.out_index !== 64'd112) begin
            n_fail++;
            $display("FAIL single_edge2 valid=%b idx=%0d exp 1/112",
                     rep_if.out_valid, rep_if.out_index);
        end
        tick();
        n_checks++;
        if (reported !== 6'd1 || rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept reported=%0d valid=%b exp 1/0",
                     reported, rep_if.out_valid);
        end
        hit[1*W+3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (rep_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_repeat cyc=%0d valid=%b exp=0",
                         i, rep_if.out_valid);
            end
        end
        hit = '0;
        tick();
        tick();
        n_checks++;
        if (reported !== 6'd1 || rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_final reported=%0d valid=%b exp 1/0",
                     reported, rep_if.out_valid);
        end
    endtask

    task automatic test_all_hits();
        rep_if.out_ready = 1'b1;
        pulse_clear();
        n_checks++;
        if (reported !== 6'd0) begin
            n_fail++;
            $display("FAIL all_clear reported=%0d exp=0", reported);
        end
        hit = '1;
        tick();
        hit = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++;
            if (rep_if.out_valid !== 1'b1 ||
                rep_if.out_index !== full_order(k)) begin
                n_fail++;
                $display("FAIL all_seq k=%0d valid=%b idx=%0d exp=%0d",
                         k, rep_if.out_valid, rep_if.out_index, full_order(k));
            end
        end
        tick();
        n_checks++;
        if (all_done !== 1'b1 || rep_if.out_valid !== 1'b0 ||
            reported !== 6'd36) begin
            n_fail++;
            $display("FAIL all_done done=%b valid=%b rep=%0d exp 1/0/36",
                     all_done, rep_if.out_valid, reported);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [63:0] got [$];
        logic [63:0] prev_idx;
        bit          prev_hold;
        prev_hold = 0;
        prev_idx  = '0;
        rep_if.out_ready = 1'b0;
        pulse_clear();
        hit = '1;
        tick();
        hit = '0;
        for (int c = 0; c < 200 && got.size() < N; c++) begin
            tick();
            if (prev_hold) begin
                n_checks++;
                if (rep_if.out_valid !== 1'b1 ||
                    rep_if.out_index !== prev_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold valid=%b idx=%0d exp 1/%0d",
                             rep_if.out_valid, rep_if.out_index, prev_idx);
                end
            end
            rep_if.out_ready = (c % 2 == 1);
            if (rep_if.out_valid === 1'b1 && rep_if.out_ready)
                got.push_back(rep_if.out_index);
            prev_hold = (rep_if.out_valid === 1'b1) && !rep_if.out_ready;
            prev_idx  = rep_if.out_index;
        end
        tick();
        n_checks++;
        if (got.size() != N) begin
            n_fail++;
            $display("FAIL stall_count got=%0d exp=%0d", got.size(), N);
        end
        for (int k = 0; k < got.size() && k < N; k++) begin
            n_checks++;
            if (got[k] !== full_order(k)) begin
                n_fail++;
                $display("FAIL stall_seq k=%0d got=%0d exp=%0d",
                         k, got[k], full_order(k));
            end
        end
        n_checks++;
        if (reported !== 6'd36 || rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_reported rep=%0d valid=%b exp 36/0",
                     reported, rep_if.out_valid);
        end
        rep_if.out_ready = 1'b0;
    endtask

    task automatic test_clear_inflight();
        rep_if.out_ready = 1'b0;
        pulse_clear();
        hit       = '0;
        hit[0]    = 1'b1;
        hit[1*W]  = 1'b1;
        tick();
        hit = '0;
        tick();
        n_checks++;
        if (rep_if.out_valid !== 1'b1 || rep_if.out_index !== 64'd100) begin
            n_fail++;
            $display("FAIL clr_first valid=%b idx=%0d exp 1/100",
                     rep_if.out_valid, rep_if.out_index);
        end
        rep_if.out_ready = 1'b1;
        tick();
        n_checks++;
        if (rep_if.out_index !== 64'd109 || reported !== 6'd1) begin
            n_fail++;
            $display("FAIL clr_second idx=%0d rep=%0d exp 109/1",
                     rep_if.out_index, reported);
        end
        rep_if.out_ready = 1'b0;
        pulse_clear();
        n_checks++;
        if (rep_if.out_valid !== 1'b1 || rep_if.out_index !== 64'd109 ||
            reported !== 6'd0) begin
            n_fail++;
            $display("FAIL clr_keep valid=%b idx=%0d rep=%0d exp 1/109/0",
                     rep_if.out_valid, rep_if.out_index, reported);
        end
        rep_if.out_ready = 1'b1;
        tick();
        n_checks++;
        if (reported !== 6'd1 || rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_epoch rep=%0d valid=%b exp 1/0",
                     reported, rep_if.out_valid);
        end
        hit[0] = 1'b1;
        tick();
        hit = '0;
        tick();
        n_checks++;
        if (rep_if.out_valid !== 1'b1 || rep_if.out_index !== 64'd100) begin
            n_fail++;
            $display("FAIL clr_rehit valid=%b idx=%0d exp 1/100",
                     rep_if.out_valid, rep_if.out_index);
        end
        tick();
        n_checks++;
        if (reported !== 6'd2) begin
            n_fail++;
            $display("FAIL clr_rehit_count rep=%0d exp=2", reported);
        end
    endtask

    task automatic test_enable_off();
        rep_if.out_ready = 1'b1;
        pulse_clear();
        enable = 1'b0;
        hit    = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (rep_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL en_off cyc=%0d valid=%b exp=0",
                         i, rep_if.out_valid);
            end
        end
        hit    = '0;
        enable = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rep_if.out_valid !== 1'b0 || reported !== 6'd0) begin
            n_fail++;
            $display("FAIL en_off_after valid=%b rep=%0d exp 0/0",
                     rep_if.out_valid, reported);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp_mid [6];
        exp_mid = '{64'd100, 64'd110, 64'd120, 64'd130, 64'd104, 64'd135};
        rep_if.out_ready = 1'b0;
        enable = 1'b1;
        pulse_clear();
        hit     = '0;
        hit[0]  = 1'b1;
        hit[4]  = 1'b1;
        hit[10] = 1'b1;
        hit[20] = 1'b1;
        hit[30] = 1'b1;
        hit[35] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rep_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre valid=%b exp=1", rep_if.out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (rep_if.out_valid !== 1'b0 || rep_if.out_index !== 64'd0 ||
            reported !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_async valid=%b idx=%0d rep=%0d exp 0/0/0",
                     rep_if.out_valid, rep_if.out_index, reported);
        end
        @(negedge clock);
        reset            = 1'b1;
        rep_if.out_ready = 1'b1;
        tick();
        hit = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (rep_if.out_valid !== 1'b1 ||
                rep_if.out_index !== exp_mid[k]) begin
                n_fail++;
                $display("FAIL mid_seq k=%0d valid=%b idx=%0d exp=%0d",
                         k, rep_if.out_valid, rep_if.out_index, exp_mid[k]);
            end
        end
        tick();
        n_checks++;
        if (reported !== 6'd6 || rep_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_count rep=%0d valid=%b exp 6/0",
                     reported, rep_if.out_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++)
                hit[p] = ($urandom_range(0, 15) == 0);
            enable           = ($urandom_range(0, 9) != 0);
            clear            = ($urandom_range(0, 59) == 0);
            rep_if.out_ready = ($urandom_range(0, 9) < 6);
            model_step(hit, enable, clear, rep_if.out_ready);
            tick();
            n_checks++;
            if (rep_if.out_valid !== m_valid ||
                (m_valid && rep_if.out_index !== m_idx)) begin
                n_fail++;
                $display("FAIL rand_out c=%0d valid=%b idx=%0d exp %b/%0d",
                         c, rep_if.out_valid, rep_if.out_index,
                         m_valid, m_idx);
            end
            n_checks++;
            if (reported !== 6'(m_cnt) || all_done !== (m_cnt == N)) begin
                n_fail++;
                $display("FAIL rand_count c=%0d rep=%0d done=%b exp %0d",
                         c, reported, all_done, m_cnt);
            end
        end
        hit   = '0;
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_hits();
        test_back_to_back_stall();
        test_clear_inflight();
        test_enable_off();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
